// File: rtl/sq_commit_unit.sv
// Store-queue drain controller: waits for the SQ head to reach the ROB head, reads its
// operands, issues one aligned dmem write and reports completion to both SQ and ROB.
package rv32i_types;
    localparam int ROB_ADDR_WIDTH = 4;
    localparam int PHYS_WIDTH     = 6;
endpackage

module sq_commit_unit
    import rv32i_types::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sq_head_valid,
    input  logic [ROB_ADDR_WIDTH-1:0] sq_rob_idx,
    input  logic [2:0]                sq_funct3,
    input  logic [31:0]               sq_imm,
    input  logic [PHYS_WIDTH-1:0]     sq_rs1_paddr,
    input  logic [PHYS_WIDTH-1:0]     sq_rs2_paddr,
    output logic                      sq_dequeue,
    output logic [PHYS_WIDTH-1:0]     prf_rs1_addr,
    output logic [PHYS_WIDTH-1:0]     prf_rs2_addr,
    input  logic [31:0]               prf_rs1_rdata,
    input  logic [31:0]               prf_rs2_rdata,
    input  logic                      rob_head_valid,
    input  logic [ROB_ADDR_WIDTH-1:0] rob_head_idx,
    output logic                      store_done,
    output logic [ROB_ADDR_WIDTH-1:0] store_done_rob_idx,
    output logic                      store_misaligned,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_wmask,
    output logic [31:0]               dmem_wdata,
    output logic [3:0]                dmem_rmask,
    input  logic                      dmem_resp,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {IDLE, READ, ISSUE, WAIT_RESP} state_t;

    state_t                    state_q;
    logic [ROB_ADDR_WIDTH-1:0] rob_idx_q;
    logic [2:0]                funct3_q;
    logic [31:0]               imm_q;
    logic [31:0]               dmem_addr_q;
    logic [31:0]               dmem_wdata_q;
    logic [3:0]                dmem_wmask_q;

    logic        commit_match;
    logic [31:0] ea;
    logic [1:0]  off;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic        misaligned;
    logic        done_fire;

    assign commit_match = sq_head_valid && rob_head_valid && (rob_head_idx == sq_rob_idx);

    // The register file reads synchronously, so presenting the head's sources every
    // cycle makes the data for READ land exactly in ISSUE.
    assign prf_rs1_addr = sq_rs1_paddr;
    assign prf_rs2_addr = sq_rs2_paddr;

    always_comb begin
        ea         = prf_rs1_rdata + imm_q;
        off        = ea[1:0];
        wdata_d    = prf_rs2_rdata << {off, 3'b000};
        wmask_d    = 4'b0000;
        misaligned = 1'b0;
        case (funct3_q)
            3'b000: wmask_d = 4'b0001 << off;
            3'b001: begin
                wmask_d    = 4'b0011 << off;
                misaligned = off[0];
            end
            3'b010: begin
                wmask_d    = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // dmem handshake: the request is valid while dmem_wmask != 0 and is held unchanged
    // until dmem_resp; dmem_resp counts only in WAIT_RESP and completes the request that cycle.
    assign done_fire = ((state_q == ISSUE) && misaligned) ||
                       ((state_q == WAIT_RESP) && dmem_resp);

    assign sq_dequeue         = done_fire;
    assign store_done         = done_fire;
    assign store_misaligned   = (state_q == ISSUE) && misaligned;
    assign store_done_rob_idx = rob_idx_q;
    assign dmem_addr          = dmem_addr_q;
    assign dmem_wmask         = dmem_wmask_q;
    assign dmem_wdata         = dmem_wdata_q;
    assign dmem_rmask         = 4'b0000;
    assign dbg_state_o        = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rob_idx_q    <= '0;
            funct3_q     <= '0;
            imm_q        <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit_match) state_q <= READ;
                end
                READ: begin
                    rob_idx_q <= sq_rob_idx;
                    funct3_q  <= sq_funct3;
                    imm_q     <= sq_imm;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    if (misaligned) begin
                        state_q <= IDLE;
                    end else begin
                        dmem_addr_q  <= {ea[31:2], 2'b00};
                        dmem_wmask_q <= wmask_d;
                        dmem_wdata_q <= wdata_d;
                        state_q      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (dmem_resp) begin
                        dmem_wmask_q <= 4'b0000;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sq_commit_unit.sv
// Directed bench for sq_commit_unit: SQ/ROB/PRF/memory models around the DUT, a
// scoreboard of expected dmem writes and completions, and per-test latency checks.
module tb_sq_commit_unit;
    localparam int EXP_W = 73;  // {mis, idx[3:0], addr[31:0], wmask[3:0], wdata[31:0]}

    typedef struct packed {
        logic [3:0]  idx;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
    } sq_ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sq_head_valid = 1'b0;
    logic [3:0]  sq_rob_idx = '0;
    logic [2:0]  sq_funct3 = '0;
    logic [31:0] sq_imm = '0;
    logic [5:0]  sq_rs1_paddr = '0;
    logic [5:0]  sq_rs2_paddr = '0;
    logic        sq_dequeue;
    logic [5:0]  prf_rs1_addr, prf_rs2_addr;
    logic [31:0] prf_rs1_rdata = '0;
    logic [31:0] prf_rs2_rdata = '0;
    logic        rob_head_valid = 1'b0;
    logic [3:0]  rob_head_idx = '0;
    logic        store_done;
    logic [3:0]  store_done_rob_idx;
    logic        store_misaligned;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_rmask;
    logic        dmem_resp;
    logic [1:0]  dbg_state_o;

    logic [31:0] prf [64];
    sq_ent_t     sq_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int          deq_cyc_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int sq_rd = 0;
    int deq_seen = 0;
    int exp_rd = 0;
    int deq_count = 0;
    int wmask_cycles = 0;
    int wfirst_cyc = 0;
    int mis_cyc = 0;
    int wait_cnt = 0;
    int mem_lat = 1;
    logic mem_en = 1'b1;
    logic auto_resp = 1'b0;
    logic stale_resp = 1'b0;
    logic rob_auto = 1'b1;
    logic rob_man_valid = 1'b0;
    logic [3:0] rob_man_idx = '0;
    logic prev_wz = 1'b1;
    sq_ent_t head = '0;
    logic [EXP_W-1:0] mon_e;

    assign dmem_resp = auto_resp | stale_resp;

    sq_commit_unit dut (
        .clk(clk), .rst(rst),
        .sq_head_valid(sq_head_valid), .sq_rob_idx(sq_rob_idx), .sq_funct3(sq_funct3),
        .sq_imm(sq_imm), .sq_rs1_paddr(sq_rs1_paddr), .sq_rs2_paddr(sq_rs2_paddr),
        .sq_dequeue(sq_dequeue),
        .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
        .prf_rs1_rdata(prf_rs1_rdata), .prf_rs2_rdata(prf_rs2_rdata),
        .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
        .store_done(store_done), .store_done_rob_idx(store_done_rob_idx),
        .store_misaligned(store_misaligned),
        .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rmask(dmem_rmask), .dmem_resp(dmem_resp),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- models ----------------
    always @(posedge clk) begin
        prf_rs1_rdata <= prf[prf_rs1_addr];
        prf_rs2_rdata <= prf[prf_rs2_addr];
    end

    // SQ and ROB head: the SQ pops on the edge after a dequeue; in auto mode the ROB head
    // tracks the SQ head, otherwise the test drives it.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            sq_rd    = sq_q.size();
            deq_seen = deq_count;
        end else if (deq_count > deq_seen) begin
            sq_rd++;
            deq_seen = deq_count;
        end
        if (sq_rd < sq_q.size()) begin
            head          = sq_q[sq_rd];
            sq_head_valid = 1'b1;
        end else begin
            sq_head_valid = 1'b0;
        end
        sq_rob_idx     = head.idx;
        sq_funct3      = head.f3;
        sq_imm         = head.imm;
        sq_rs1_paddr   = head.rs1;
        sq_rs2_paddr   = head.rs2;
        rob_head_valid = rob_auto ? sq_head_valid : rob_man_valid;
        rob_head_idx   = rob_auto ? head.idx : rob_man_idx;
    end

    // Memory acknowledges mem_lat cycles after the request first appears (L=1: same cycle).
    always @(posedge clk) begin
        #1;
        if (mem_en && dmem_wmask != 4'b0000) begin
            if (wait_cnt == mem_lat - 1) begin
                auto_resp = 1'b1;
                wait_cnt  = 0;
            end else begin
                auto_resp = 1'b0;
                wait_cnt++;
            end
        end else begin
            auto_resp = 1'b0;
            wait_cnt  = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_rd  = exp_q.size();
            prev_wz = 1'b1;
        end else begin
            if (dmem_wmask != 4'b0000) begin
                wmask_cycles++;
                if (prev_wz) wfirst_cyc = cyc;
                if (exp_rd >= exp_q.size()) begin
                    check_val("stray_wmask", {28'd0, dmem_wmask}, 32'd0);
                end else begin
                    mon_e = exp_q[exp_rd];
                    check_val("dmem_addr", dmem_addr, mon_e[67:36]);
                    check_val("dmem_wmask", {28'd0, dmem_wmask}, {28'd0, mon_e[35:32]});
                    check_val("dmem_wdata", dmem_wdata, mon_e[31:0]);
                end
            end
            prev_wz = (dmem_wmask == 4'b0000);
            if (store_misaligned) begin
                mis_cyc = cyc;
                check_val("mis_qualifies_done", {31'd0, store_done}, 32'd1);
            end
            if (sq_dequeue || store_done) begin
                check_val("done_with_deq", {31'd0, store_done}, {31'd0, sq_dequeue});
                check_val("deq_head_valid", {31'd0, sq_head_valid}, 32'd1);
                check_val("rmask_zero", {28'd0, dmem_rmask}, 32'd0);
                deq_count++;
                deq_cyc_q.push_back(cyc);
                if (exp_rd >= exp_q.size()) begin
                    check_val("stray_deq", {31'd0, sq_dequeue}, 32'd0);
                end else begin
                    mon_e = exp_q[exp_rd];
                    check_val("done_rob_idx", {28'd0, store_done_rob_idx}, {28'd0, mon_e[71:68]});
                    check_val("done_misaligned", {31'd0, store_misaligned}, {31'd0, mon_e[72]});
                    exp_rd++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_store(input logic [3:0] idx, input logic [2:0] f3, input logic [31:0] imm,
                              input logic [5:0] rs1, input logic [5:0] rs2, input logic mis,
                              input logic [31:0] e_addr, input logic [3:0] e_mask,
                              input logic [31:0] e_wdata);
        sq_q.push_back('{idx: idx, f3: f3, imm: imm, rs1: rs1, rs2: rs2});
        exp_q.push_back({mis, idx, e_addr, e_mask, e_wdata});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_deqs(input int target, input int budget);
        int k;
        k = 0;
        while (deq_count < target && k < budget) begin
            step(1);
            k++;
        end
        check_val("deq_count", deq_count, target);
    endtask

    // ---------------- directed tests ----------------
    int d0, w0, w1, c0, c1, gate_bad, k;

    initial begin
        for (int i = 0; i < 64; i++) prf[i] = 32'd0;
        prf[1]  = 32'h0000_1000;
        prf[2]  = 32'hDEAD_BEEF;
        prf[3]  = 32'h0000_2003;
        prf[4]  = 32'h0000_00AB;
        prf[5]  = 32'h0000_2000;
        prf[6]  = 32'h0000_1234;
        prf[8]  = 32'h1122_3344;
        prf[10] = 32'h0000_0004;
        prf[11] = 32'h0000_3000;
        prf[12] = 32'hCAFE_F00D;
        prf[13] = 32'h1111_1111;
        prf[14] = 32'h2222_2222;
        prf[15] = 32'h3333_3333;

        // reset values
        step(3);
        check_val("rst_deq", {31'd0, sq_dequeue}, 32'd0);
        check_val("rst_done", {31'd0, store_done}, 32'd0);
        check_val("rst_mis", {31'd0, store_misaligned}, 32'd0);
        check_val("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
        check_val("rst_rmask", {28'd0, dmem_rmask}, 32'd0);
        check_val("rst_addr", dmem_addr, 32'd0);
        check_val("rst_wdata", dmem_wdata, 32'd0);
        check_val("rst_done_idx", {28'd0, store_done_rob_idx}, 32'd0);
        rst = 1'b0;
        step(1);

        // single SW, L=1
        mem_lat = 1;
        d0 = deq_count;
        w0 = wmask_cycles;
        push_store(4'd3, 3'b010, 32'd4, 6'd1, 6'd2, 1'b0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF);
        c0 = cyc + 1;
        wait_deqs(d0 + 1, 20);
        check_val("sw_deq_lat", deq_cyc_q[d0] - c0, 32'd3);
        check_val("sw_req_lat", wfirst_cyc - c0, 32'd3);
        check_val("sw_wmask_cycles", wmask_cycles - w0, 32'd1);

        // byte/half lanes, shifted-out bits, address wrap; back-to-back at L=1
        d0 = deq_count;
        push_store(4'd4, 3'b000, 32'd0, 6'd3, 6'd4, 1'b0, 32'h0000_2000, 4'b1000, 32'hAB00_0000);
        push_store(4'd5, 3'b001, 32'd2, 6'd5, 6'd6, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_0000);
        push_store(4'd6, 3'b000, 32'd2, 6'd5, 6'd8, 1'b0, 32'h0000_2000, 4'b0100, 32'h3344_0000);
        push_store(4'd7, 3'b010, 32'hFFFF_FFF8, 6'd10, 6'd8, 1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h1122_3344);
        c0 = cyc + 1;
        wait_deqs(d0 + 4, 40);
        check_val("lane_first_deq", deq_cyc_q[d0] - c0, 32'd3);
        for (int i = 1; i < 4; i++)
            check_val("lane_spacing", deq_cyc_q[d0 + i] - deq_cyc_q[d0 + i - 1], 32'd4);

        // commit gating: ROB head points elsewhere for 10 cycles
        rob_auto      = 1'b0;
        rob_man_valid = 1'b1;
        rob_man_idx   = 4'd9;
        d0 = deq_count;
        w0 = wmask_cycles;
        push_store(4'd6, 3'b010, 32'd8, 6'd1, 6'd12, 1'b0, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D);
        gate_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (prf_rs1_addr !== 6'd1 || prf_rs2_addr !== 6'd12) gate_bad++;
        end
        check_val("gate_prf_addr", gate_bad, 32'd0);
        check_val("gate_no_deq", deq_count - d0, 32'd0);
        check_val("gate_no_wmask", wmask_cycles - w0, 32'd0);
        rob_man_idx = 4'd6;
        c0 = cyc + 1;
        wait_deqs(d0 + 1, 20);
        check_val("gate_deq_lat", deq_cyc_q[d0] - c0, 32'd3);
        rob_auto = 1'b1;
        step(1);

        // misaligned SW, then misaligned SH and illegal funct3 back-to-back
        d0 = deq_count;
        w0 = wmask_cycles;
        push_store(4'd7, 3'b010, 32'd2, 6'd11, 6'd2, 1'b1, 32'd0, 4'b0000, 32'd0);
        c0 = cyc + 1;
        wait_deqs(d0 + 1, 20);
        check_val("mis_report_cyc", mis_cyc - c0, 32'd2);
        check_val("mis_deq_cyc", deq_cyc_q[d0] - c0, 32'd2);
        push_store(4'd8, 3'b001, 32'd1, 6'd11, 6'd2, 1'b1, 32'd0, 4'b0000, 32'd0);
        push_store(4'd9, 3'b011, 32'd0, 6'd11, 6'd2, 1'b1, 32'd0, 4'b0000, 32'd0);
        c1 = cyc + 1;
        wait_deqs(d0 + 3, 20);
        check_val("mis_sh_deq_cyc", deq_cyc_q[d0 + 1] - c1, 32'd2);
        check_val("mis_spacing", deq_cyc_q[d0 + 2] - deq_cyc_q[d0 + 1], 32'd3);
        step(4);
        check_val("mis_one_deq_each", deq_count - d0, 32'd3);
        check_val("mis_no_wmask", wmask_cycles - w0, 32'd0);

        // three SWs back-to-back with L=4
        mem_lat = 4;
        d0 = deq_count;
        w0 = wmask_cycles;
        push_store(4'd10, 3'b010, 32'h10, 6'd1, 6'd13, 1'b0, 32'h0000_1010, 4'b1111, 32'h1111_1111);
        push_store(4'd11, 3'b010, 32'h20, 6'd1, 6'd14, 1'b0, 32'h0000_1020, 4'b1111, 32'h2222_2222);
        push_store(4'd12, 3'b010, 32'h30, 6'd1, 6'd15, 1'b0, 32'h0000_1030, 4'b1111, 32'h3333_3333);
        c0 = cyc + 1;
        wait_deqs(d0 + 3, 60);
        check_val("slow_first_deq", deq_cyc_q[d0] - c0, 32'd6);
        check_val("slow_spacing_1", deq_cyc_q[d0 + 1] - deq_cyc_q[d0], 32'd7);
        check_val("slow_spacing_2", deq_cyc_q[d0 + 2] - deq_cyc_q[d0 + 1], 32'd7);
        check_val("slow_wmask_cycles", wmask_cycles - w0, 32'd12);

        // reset while waiting for the response, then a stale response
        mem_lat = 6;
        d0 = deq_count;
        w0 = wmask_cycles;
        push_store(4'd13, 3'b010, 32'h40, 6'd1, 6'd2, 1'b0, 32'h0000_1040, 4'b1111, 32'hDEAD_BEEF);
        k = 0;
        while (wmask_cycles == w0 && k < 20) begin
            step(1);
            k++;
        end
        check_val("rstw_req_seen", (wmask_cycles > w0) ? 32'd1 : 32'd0, 32'd1);
        mem_en = 1'b0;
        rst    = 1'b1;
        step(1);
        rst = 1'b0;
        check_val("rstw_wmask", {28'd0, dmem_wmask}, 32'd0);
        check_val("rstw_addr", dmem_addr, 32'd0);
        w1 = wmask_cycles;
        stale_resp = 1'b1;
        step(2);
        stale_resp = 1'b0;
        step(6);
        check_val("rstw_no_deq", deq_count - d0, 32'd0);
        check_val("rstw_no_wmask", wmask_cycles - w1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
